pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits (1..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into data registers on reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-007 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-008 SHALL have port in_ready, output, 1, stage accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a valid entry.
REQ-010 SHALL have port out_data, output, WIDTH, oldest held entry.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes out_data this cycle.
REQ-012 SHALL have port occ, output, 2, number of held entries (0..2).

Function
REQ-013 SHALL hold entries in two WIDTH-bit registers, main and skid, with state EMPTY (occ 0), BUSY (occ 1, main), FULL (occ 2, main older than skid).
REQ-014 SHALL drive in_ready = (state != FULL), directly from a state flop, no combinational path from out_ready.
REQ-015 SHALL drive out_valid = (state != EMPTY) and out_data = main, both register outputs.
REQ-016 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both evaluated at the same edge.
REQ-017 EMPTY: transfer in -> main <= in_data, BUSY; else stay EMPTY.
REQ-018 BUSY: in & out -> main <= in_data, stay BUSY; out only -> EMPTY; in only -> skid <= in_data, FULL; neither -> stay.
REQ-019 FULL: out -> main <= skid, BUSY; else stay FULL; no input accepted (in_ready low).
REQ-020 SHALL pass data with one-cycle latency from in transfer to out_valid when EMPTY; order SHALL be strictly FIFO, no entry lost or duplicated.
REQ-021 flush SHALL take priority over all transfers: next state EMPTY, occ 0, in_ready 1; data registers hold contents; an in transfer in the flush cycle is discarded.
REQ-022 Registers not written in a cycle SHALL hold their value (no spurious loads when in_valid low).
REQ-023 occ SHALL equal 0/1/2 for EMPTY/BUSY/FULL, registered.

Reset
REQ-024 clr high SHALL immediately, without clk, force state EMPTY, occ 0, out_valid 0, in_ready 1, main = skid = RESET_VAL.
REQ-025 clr asserted mid-transfer SHALL discard all held entries; first accept after clr deassertion SHALL occur on the first rising clk edge with in_valid high.

Structure
REQ-026 State encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL live in the shared pipeline package/include with other pipeline constants.
REQ-027 main and skid SHALL each be an instance of sub-module dffe_w (parametrised WIDTH register with async active-high clear to RESET_VAL and write enable); control SHALL be in pipe_skid_reg.

Verification
REQ-028 Reset: clr pulse mid-cycle with occ 2 -> out_valid 0, in_ready 1, occ 0, out_data 0 before next clk edge.
REQ-029 Streaming: out_ready held 1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, occ stays 1, in_ready stays 1.
REQ-030 Backpressure: out_ready 0, push 0xA5A5A5A5 then 0x5A5A5A5A -> occ 2, in_ready 0, third offer 0xFFFFFFFF not accepted; release out_ready -> 0xA5A5A5A5 then 0x5A5A5A5A, then 0xFFFFFFFF accepted.
REQ-031 Flush: occ 2, flush with in_valid 1 (0xDEAD0000) -> next cycle occ 0, out_valid 0, in_ready 1, 0xDEAD0000 never appears at output.
REQ-032 Simultaneous: BUSY holding 0x1, in_valid 1 with 0x2 and out_ready 1 -> next cycle out_data 0x2, occ 1.
REQ-033 Width: WIDTH=8, RESET_VAL=8'h7F -> after clr out_data 8'h7F; random in/out stall 10000 cycles -> scoreboard in-order match, no loss.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline constants for the skid-buffered register stage:
// state encoding and occupancy helper.
package pipe_skid_reg_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   function automatic logic [OCC_W-1:0] occ_of(input skid_state_e st);
      case (st)
         ST_BUSY: occ_of = 2'd1;
         ST_FULL: occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_reg_dffe_w.sv
// WIDTH-bit register with write enable and async active-high clear to RESET_VAL.
module dffe_w #(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = en ? d : q_q;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) q_q <= RESET_VAL;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: fully registered valid/ready, so in_ready
// never depends combinationally on out_ready.
module pipe_skid_reg #(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occ
);

   import pipe_skid_reg_pkg::*;

   skid_state_e      state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             main_en, skid_en;
   logic [WIDTH-1:0] main_d, main_q, skid_q;
   logic             xfer_in, xfer_out;

   assign xfer_in  = in_valid & in_ready_q;
   assign xfer_out = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = in_data;
      // flush drops everything, including a transfer offered this cycle
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (xfer_in) begin
                  main_en = 1'b1;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (xfer_in && xfer_out) begin
                  main_en = 1'b1;
               end else if (xfer_out) begin
                  state_d = ST_EMPTY;
               end else if (xfer_in) begin
                  skid_en = 1'b1;
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (xfer_out) begin
                  main_en = 1'b1;
                  main_d  = skid_q;
                  state_d = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
      occ_d       = occ_of(state_d);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occ_q       <= occ_d;
      end
   end

   dffe_w #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk (clk),
      .clr (clr),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   dffe_w #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk (clk),
      .clr (clr),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg at WIDTH=32 and WIDTH=8.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        clr = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  occ;

   logic        clr8 = 1'b0, flush8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0]  in_data8 = '0;
   logic        in_ready8, out_valid8;
   logic [7:0]  out_data8;
   logic [1:0]  occ8;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pipe_skid_reg dut (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .occ(occ)
   );

   pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h7F)) dut8 (
      .clk(clk), .clr(clr8), .flush(flush8), .in_valid(in_valid8), .in_data(in_data8),
      .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
      .out_ready(out_ready8), .occ(occ8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 clr = 1'b1;
      #2;
      nvec++;
      if ({out_valid, in_ready, occ, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         nerr++;
         $display("FAIL reset_init: got ov=%b ir=%b occ=%0d data=%h want ov=0 ir=1 occ=0 data=0",
                  out_valid, in_ready, occ, out_data);
      end
      step();
      clr = 1'b0;
      // fill to FULL then clear asynchronously mid-cycle
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_0001;
      step();
      in_data = 32'hAAAA_0002;
      step();
      in_valid = 1'b0;
      nvec++;
      if (occ !== 2'd2) begin
         nerr++;
         $display("FAIL reset_fill: got occ=%0d want occ=2", occ);
      end
      #2 clr = 1'b1;
      #1;
      nvec++;
      if ({out_valid, in_ready, occ, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
         nerr++;
         $display("FAIL reset_async: got ov=%b ir=%b occ=%0d data=%h want ov=0 ir=1 occ=0 data=0",
                  out_valid, in_ready, occ, out_data);
      end
      #1 clr = 1'b0;
      in_valid = 1'b1; in_data = 32'h00C0_FFEE; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      nvec++;
      if ({out_valid, occ, out_data} !== {1'b1, 2'd1, 32'h00C0_FFEE}) begin
         nerr++;
         $display("FAIL reset_first_accept: got ov=%b occ=%0d data=%h want ov=1 occ=1 data=00c0ffee",
                  out_valid, occ, out_data);
      end
      step();
      nvec++;
      if (occ !== 2'd0 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_drain: got ov=%b occ=%0d want ov=0 occ=0", out_valid, occ);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = vals[i];
         step();
         nvec++;
         if ({out_valid, in_ready, occ, out_data} !== {1'b1, 1'b1, 2'd1, vals[i]}) begin
            nerr++;
            $display("FAIL stream_%0d: got ov=%b ir=%b occ=%0d data=%h want ov=1 ir=1 occ=1 data=%h",
                     i, out_valid, in_ready, occ, out_data, vals[i]);
         end
      end
      in_valid = 1'b0;
      step();
      nvec++;
      if (occ !== 2'd0 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL stream_drain: got ov=%b occ=%0d want ov=0 occ=0", out_valid, occ);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_A5A5;
      step();
      in_data = 32'h5A5A_5A5A;
      step();
      nvec++;
      if ({occ, in_ready, out_data} !== {2'd2, 1'b0, 32'hA5A5_A5A5}) begin
         nerr++;
         $display("FAIL bp_full: got occ=%0d ir=%b data=%h want occ=2 ir=0 data=a5a5a5a5",
                  occ, in_ready, out_data);
      end
      in_data = 32'hFFFF_FFFF;
      step();
      nvec++;
      if ({occ, in_ready, out_data} !== {2'd2, 1'b0, 32'hA5A5_A5A5}) begin
         nerr++;
         $display("FAIL bp_hold: got occ=%0d ir=%b data=%h want occ=2 ir=0 data=a5a5a5a5",
                  occ, in_ready, out_data);
      end
      out_ready = 1'b1;
      step();
      nvec++;
      if ({occ, in_ready, out_data} !== {2'd1, 1'b1, 32'h5A5A_5A5A}) begin
         nerr++;
         $display("FAIL bp_release: got occ=%0d ir=%b data=%h want occ=1 ir=1 data=5a5a5a5a",
                  occ, in_ready, out_data);
      end
      step();
      in_valid = 1'b0;
      nvec++;
      if ({occ, out_valid, out_data} !== {2'd1, 1'b1, 32'hFFFF_FFFF}) begin
         nerr++;
         $display("FAIL bp_third: got occ=%0d ov=%b data=%h want occ=1 ov=1 data=ffffffff",
                  occ, out_valid, out_data);
      end
      step();
      nvec++;
      if (occ !== 2'd0) begin
         nerr++;
         $display("FAIL bp_drain: got occ=%0d want occ=0", occ);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      step();
      in_data = 32'h2;
      step();
      flush   = 1'b1;
      in_data = 32'hDEAD_0000;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      nvec++;
      if ({occ, out_valid, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL flush_state: got occ=%0d ov=%b ir=%b want occ=0 ov=0 ir=1",
                  occ, out_valid, in_ready);
      end
      nvec++;
      if (out_data !== 32'h1) begin
         nerr++;
         $display("FAIL flush_hold: got data=%h want data=00000001", out_data);
      end
      in_valid = 1'b1;
      in_data  = 32'h3;
      step();
      in_data = 32'h4;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      nvec++;
      if ({occ, out_data} !== {2'd2, 32'h3}) begin
         nerr++;
         $display("FAIL flush_refill: got occ=%0d data=%h want occ=2 data=00000003", occ, out_data);
      end
      step();
      nvec++;
      if ({occ, out_data} !== {2'd1, 32'h4}) begin
         nerr++;
         $display("FAIL flush_order: got occ=%0d data=%h want occ=1 data=00000004", occ, out_data);
      end
      step();
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      step();
      in_valid = 1'b0;
      in_data  = 32'hBAD0_BAD0;
      step();
      nvec++;
      if ({occ, out_data} !== {2'd1, 32'h1}) begin
         nerr++;
         $display("FAIL idle_hold: got occ=%0d data=%h want occ=1 data=00000001", occ, out_data);
      end
      in_valid  = 1'b1;
      in_data   = 32'h2;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      nvec++;
      if ({occ, out_data} !== {2'd1, 32'h2}) begin
         nerr++;
         $display("FAIL simultaneous: got occ=%0d data=%h want occ=1 data=00000002", occ, out_data);
      end
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_width8_random();
      logic [7:0] sb [$];
      logic [7:0] exp_d;
      #1 clr8 = 1'b1;
      #1;
      nvec++;
      if ({out_data8, out_valid8, in_ready8, occ8} !== {8'h7F, 1'b0, 1'b1, 2'd0}) begin
         nerr++;
         $display("FAIL w8_reset: got data=%h ov=%b ir=%b occ=%0d want data=7f ov=0 ir=1 occ=0",
                  out_data8, out_valid8, in_ready8, occ8);
      end
      step();
      clr8 = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         in_valid8  = ($urandom_range(0, 3) != 0);
         in_data8   = 8'($urandom);
         out_ready8 = ($urandom_range(0, 2) != 0);
         if (occ8 !== 2'(sb.size())) begin
            nvec++;
            nerr++;
            $display("FAIL w8_occ cycle %0d: got occ=%0d want occ=%0d", c, occ8, sb.size());
         end
         if (out_valid8 && out_ready8) begin
            nvec++;
            if (sb.size() == 0) begin
               nerr++;
               $display("FAIL w8_spurious cycle %0d: got data=%h want no valid output", c, out_data8);
            end else begin
               exp_d = sb.pop_front();
               if (out_data8 !== exp_d) begin
                  nerr++;
                  $display("FAIL w8_data cycle %0d: got data=%h want data=%h", c, out_data8, exp_d);
               end
            end
         end
         if (in_valid8 && in_ready8) sb.push_back(in_data8);
         step();
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (out_valid8 && sb.size() != 0) begin
            exp_d = sb.pop_front();
            nvec++;
            if (out_data8 !== exp_d) begin
               nerr++;
               $display("FAIL w8_drain: got data=%h want data=%h", out_data8, exp_d);
            end
         end
         step();
      end
      nvec++;
      if (sb.size() != 0 || occ8 !== 2'd0) begin
         nerr++;
         $display("FAIL w8_loss: got occ=%0d left=%0d want occ=0 left=0", occ8, sb.size());
      end
   endtask

   initial begin
      clr8 = 1'b1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_simultaneous();
      clr8 = 1'b0;
      step();
      test_width8_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
